la_scanreg: RTL and testbench

LA_SCANREG -- requirements
Module: la_scanreg

---
 rtl/la_scanreg.sv | 153 +++++++++++++++
 tb/tb_la_scanreg.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/la_scanreg.sv
// rtl/la_scanreg.sv - scan-capable register with shift-episode tracking and optional shadow stage
//
// Purpose:
//   W-bit state register r with parallel capture (en) and serial scan (se/si/so).
//   A two-state FSM with a saturating shift counter tracks each scan episode.
//   sfull is a level flag that is high while the counter sits at W. sdone is a
//   one-cycle pulse marking the first time the counter reaches W in an episode.
//   q presents the state, or the shadow copy when that stage is compiled in,
//   bitwise inverted when INV=1.
//
// Build option:
//   LA_SCANREG_SHADOW_EN - when defined, adds a W-bit shadow register sh that
//   copies r on upd while se=0, so q stays frozen during scan. When undefined,
//   q follows r directly and upd is ignored. The port list is identical in
//   both builds.
//
// Ports:
//   clk    in   1  clock, all state on rising edge
//   reset  in   1  synchronous reset, active-high
//   d      in   W  parallel capture data
//   en     in   1  capture enable
//   se     in   1  scan enable (has priority over en)
//   si     in   1  scan serial in
//   upd    in   1  shadow update strobe
//   q      out  W  data out
//   so     out  1  scan serial out, r[W-1]
//   sdone  out  1  full-chain-shifted pulse
//   sfull  out  1  full-chain level flag
module la_scanreg #(
  parameter int    W    = 8,
  parameter int    INV  = 1,
  parameter string PROP = "DEFAULT"
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  input  logic         en,
  input  logic         se,
  input  logic         si,
  input  logic         upd,
  output logic [W-1:0] q,
  output logic         so,
  output logic         sdone,
  output logic         sfull
);

  localparam int            CW       = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(W);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // PROP only tags the instance for technology mapping.
  localparam bit PROP_EMPTY = (PROP == "");

  logic [W-1:0]  r_q, r_d, r_shift;
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sdone_q, sdone_d;
  logic          sfull_q, sfull_d;
  logic [W-1:0]  src;

  // A one-bit chain has no upper bits to keep, so si replaces the whole register.
  generate
    if (W == 1) begin : g_shift_w1
      assign r_shift = si;
    end else begin : g_shift_wn
      assign r_shift = {r_q[W-2:0], si};
    end
  endgenerate

  always_comb begin
    r_d = r_q;
    if (se) begin
      r_d = r_shift;
    end else if (en) begin
      r_d = d;
    end
  end

  always_comb begin
    state_d = se ? ST_SHIFT : ST_IDLE;

    // The first scan cycle of an episode counts as shift number one. Any
    // cycle without se ends the episode.
    cnt_d = '0;
    if (se) begin
      if (state_q == ST_IDLE) begin
        cnt_d = CW'(1);
      end else if (cnt_q != CNT_FULL) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end

    sfull_d = (cnt_d == CNT_FULL);
    // Pulse only on the transition into W. A saturated counter stays at W
    // and does not pulse again.
    sdone_d = (cnt_d == CNT_FULL) && (cnt_q != CNT_FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q     <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sdone_q <= 1'b0;
      sfull_q <= 1'b0;
    end else begin
      r_q     <= r_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sdone_q <= sdone_d;
      sfull_q <= sfull_d;
    end
  end

`ifdef LA_SCANREG_SHADOW_EN
  logic [W-1:0] sh_q, sh_d;

  // The shadow copy holds while scanning so that q does not ripple.
  always_comb begin
    sh_d = sh_q;
    if (upd && !se) begin
      sh_d = r_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign src = sh_q;
`else
  assign src = r_q;
`endif

  // upd has no role in the build without the shadow stage. PROP has no
  // functional effect in any build.
  logic unused_ok;
  assign unused_ok = ^{upd, PROP_EMPTY};

  assign q     = (INV != 0) ? ~src : src;
  assign so    = r_q[W-1];
  assign sdone = sdone_q;
  assign sfull = sfull_q;

endmodule

// File: tb/tb_la_scanreg.sv
// tb/tb_la_scanreg.sv - directed self-checking bench for la_scanreg (W=8, INV=1)
module tb_la_scanreg;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d;
  logic       en, se, si, upd;
  logic [7:0] q;
  logic       so, sdone, sfull;

  int checks = 0;
  int errors = 0;

  // Reference state, advanced in step with each clock edge.
  logic [7:0] exp_r  = 8'h00;
  logic [7:0] exp_sh = 8'h00;

  la_scanreg #(.W(8), .INV(1), .PROP("DEFAULT")) dut (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .en    (en),
    .se    (se),
    .si    (si),
    .upd   (upd),
    .q     (q),
    .so    (so),
    .sdone (sdone),
    .sfull (sfull)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_q();
`ifdef LA_SCANREG_SHADOW_EN
    return ~exp_sh;
`else
    return ~exp_r;
`endif
  endfunction

  task automatic tick();
    if (reset) begin
      exp_r  = 8'h00;
      exp_sh = 8'h00;
    end else begin
      if (upd && !se) exp_sh = exp_r;
      if (se) exp_r = {exp_r[6:0], si};
      else if (en) exp_r = d;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL reset_q got=%h exp=%h", q, 8'hFF); end
    checks++; if (so !== 1'b0) begin errors++; $display("FAIL reset_so got=%b exp=0", so); end
    checks++; if (sdone !== 1'b0) begin errors++; $display("FAIL reset_sdone got=%b exp=0", sdone); end
    checks++; if (sfull !== 1'b0) begin errors++; $display("FAIL reset_sfull got=%b exp=0", sfull); end
  endtask

  task automatic test_capture();
    en = 1'b1; d = 8'hA5;
    tick();
    en = 1'b0; d = 8'h3C;
`ifdef LA_SCANREG_SHADOW_EN
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL capture_pre_upd_q got=%h exp=%h", q, 8'hFF); end
`else
    checks++; if (q !== 8'h5A) begin errors++; $display("FAIL capture_q got=%h exp=%h", q, 8'h5A); end
`endif
    upd = 1'b1;
    tick();
    upd = 1'b0;
    checks++; if (q !== 8'h5A) begin errors++; $display("FAIL capture_upd_q got=%h exp=%h", q, 8'h5A); end
    tick();
    checks++; if (q !== 8'h5A) begin errors++; $display("FAIL capture_hold_q got=%h exp=%h", q, 8'h5A); end
    checks++; if (so !== 1'b1) begin errors++; $display("FAIL capture_so got=%b exp=1", so); end
  endtask

  task automatic test_full_shift();
    logic [7:0] bits;
    bits = 8'b1011_0010;
    se = 1'b1;
    for (int i = 0; i < 8; i++) begin
      si = bits[7-i];
      tick();
      checks++; if (sdone !== (i == 7)) begin errors++; $display("FAIL full_sdone shift=%0d got=%b exp=%b", i + 1, sdone, (i == 7)); end
      checks++; if (sfull !== (i == 7)) begin errors++; $display("FAIL full_sfull shift=%0d got=%b exp=%b", i + 1, sfull, (i == 7)); end
      checks++; if (q !== model_q()) begin errors++; $display("FAIL full_q shift=%0d got=%h exp=%h", i + 1, q, model_q()); end
    end
`ifdef LA_SCANREG_SHADOW_EN
    checks++; if (q !== 8'h5A) begin errors++; $display("FAIL full_final_q got=%h exp=%h", q, 8'h5A); end
`else
    checks++; if (q !== 8'h4D) begin errors++; $display("FAIL full_final_q got=%h exp=%h", q, 8'h4D); end
`endif
    checks++; if (so !== 1'b1) begin errors++; $display("FAIL full_so got=%b exp=1", so); end
    si = 1'b0;
    tick();
    checks++; if (sdone !== 1'b0) begin errors++; $display("FAIL ninth_sdone got=%b exp=0", sdone); end
    checks++; if (sfull !== 1'b1) begin errors++; $display("FAIL ninth_sfull got=%b exp=1", sfull); end
    se = 1'b0;
    tick();
    checks++; if (sfull !== 1'b0) begin errors++; $display("FAIL end_sfull got=%b exp=0", sfull); end
    checks++; if (sdone !== 1'b0) begin errors++; $display("FAIL end_sdone got=%b exp=0", sdone); end
  endtask

  task automatic test_partial_abort();
    int pulses;
    se = 1'b1;
    for (int i = 0; i < 5; i++) begin
      si = i[0];
      tick();
      checks++; if (sdone !== 1'b0) begin errors++; $display("FAIL partial_sdone shift=%0d got=%b exp=0", i + 1, sdone); end
      checks++; if (sfull !== 1'b0) begin errors++; $display("FAIL partial_sfull shift=%0d got=%b exp=0", i + 1, sfull); end
    end
    se = 1'b0;
    tick();
    checks++; if (sdone !== 1'b0) begin errors++; $display("FAIL abort_sdone got=%b exp=0", sdone); end
    checks++; if (sfull !== 1'b0) begin errors++; $display("FAIL abort_sfull got=%b exp=0", sfull); end
    checks++; if (so !== 1'b1) begin errors++; $display("FAIL abort_so got=%b exp=1", so); end
`ifndef LA_SCANREG_SHADOW_EN
    checks++; if (q !== 8'h75) begin errors++; $display("FAIL abort_q got=%h exp=%h", q, 8'h75); end
`endif
    pulses = 0;
    se = 1'b1; si = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (sdone === 1'b1) pulses++;
      checks++; if (sdone !== (i == 7)) begin errors++; $display("FAIL rerun_sdone shift=%0d got=%b exp=%b", i + 1, sdone, (i == 7)); end
    end
    se = 1'b0;
    tick();
    if (sdone === 1'b1) pulses++;
    checks++; if (pulses !== 1) begin errors++; $display("FAIL rerun_pulse_count got=%0d exp=1", pulses); end
  endtask

  task automatic test_reset_mid_shift();
    se = 1'b1; si = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL midrst_q got=%h exp=%h", q, 8'hFF); end
    checks++; if (so !== 1'b0) begin errors++; $display("FAIL midrst_so got=%b exp=0", so); end
    checks++; if (sdone !== 1'b0) begin errors++; $display("FAIL midrst_sdone got=%b exp=0", sdone); end
    checks++; if (sfull !== 1'b0) begin errors++; $display("FAIL midrst_sfull got=%b exp=0", sfull); end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (sdone !== (i == 7)) begin errors++; $display("FAIL postrst_sdone shift=%0d got=%b exp=%b", i + 1, sdone, (i == 7)); end
    end
    se = 1'b0;
    tick();
  endtask

  task automatic test_shadow();
    logic [7:0] bits;
    bits = 8'h3C;
    se = 1'b1; upd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      si = bits[7-i];
      tick();
`ifdef LA_SCANREG_SHADOW_EN
      checks++; if (q !== 8'hFF) begin errors++; $display("FAIL shadow_frozen_q shift=%0d got=%h exp=%h", i + 1, q, 8'hFF); end
`else
      checks++; if (q !== model_q()) begin errors++; $display("FAIL shadow_follow_q shift=%0d got=%h exp=%h", i + 1, q, model_q()); end
`endif
    end
    se = 1'b0;
    tick();
    upd = 1'b0;
    checks++; if (q !== 8'hC3) begin errors++; $display("FAIL shadow_upd_q got=%h exp=%h", q, 8'hC3); end
    en = 1'b1; d = 8'h00;
    tick();
    en = 1'b0;
`ifdef LA_SCANREG_SHADOW_EN
    checks++; if (q !== 8'hC3) begin errors++; $display("FAIL shadow_hold_q got=%h exp=%h", q, 8'hC3); end
`else
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL noshadow_capture_q got=%h exp=%h", q, 8'hFF); end
`endif
  endtask

  initial begin
    reset = 1'b1; d = 8'h00; en = 1'b0; se = 1'b0; si = 1'b0; upd = 1'b0;
    test_reset();
    test_capture();
    test_full_shift();
    test_partial_abort();
    test_reset_mid_shift();
    test_shadow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
